// File: rtl/filter_sum_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_sum_stage_if
// Brief    : Input vector / result bundle for the filter accumulation stage.
// Revision : 1.0 - initial release
// ============================================================================
interface filter_sum_stage_if #(
  parameter int SHIFT = 4
);
  logic                en;
  logic                in_valid;
  logic [71:0]         w_bus;
  logic [143:0]        p_bus;
  logic [11:0]         sum_b;
  logic [19:0]         sum_a;
  logic [11-SHIFT:0]   b_q;
  logic [19-SHIFT:0]   a_q;
  logic                out_valid;

  modport master (
    output en, in_valid, w_bus, p_bus,
    input  sum_b, sum_a, b_q, a_q, out_valid
  );

  modport slave (
    input  en, in_valid, w_bus, p_bus,
    output sum_b, sum_a, b_q, a_q, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/filter_sum_stage.sv
`default_nettype none
// ============================================================================
// Module   : filter_sum_stage
// Brief    : Two-stage weight/product accumulator for the 3x3 average filter.
// Revision : 1.0 - initial release
// ============================================================================

module filter_sum_stage_add5 #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
) (
  input  wire logic [IN_W-1:0]  a,
  input  wire logic [IN_W-1:0]  b,
  input  wire logic [IN_W-1:0]  c,
  input  wire logic [IN_W-1:0]  d,
  input  wire logic [IN_W-1:0]  e,
  output logic      [OUT_W-1:0] sum
);
  localparam int PAD = OUT_W - IN_W;

  assign sum = {{PAD{1'b0}}, a} + {{PAD{1'b0}}, b} + {{PAD{1'b0}}, c}
             + {{PAD{1'b0}}, d} + {{PAD{1'b0}}, e};
endmodule

module filter_sum_stage #(
  parameter int SHIFT = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  filter_sum_stage_if.slave    bus
);
  logic [7:0]  w_w [0:8];
  logic [15:0] w_p [0:8];

  // Index 0 holds w1/p1, which sit in the most significant lane of each bus.
  for (genvar k = 0; k < 9; k++) begin : g_unpack
    assign w_w[k] = bus.w_bus[71  - 8*k  -: 8];
    assign w_p[k] = bus.p_bus[143 - 16*k -: 16];
  end

  logic [11:0] w_wb_hi, w_wb_lo;
  logic [19:0] w_pa_hi, w_pa_lo;

  filter_sum_stage_add5 #(.IN_W(8), .OUT_W(12)) u_wb_hi (
    .a(w_w[4]), .b(w_w[5]), .c(w_w[6]), .d(w_w[7]), .e(w_w[8]), .sum(w_wb_hi)
  );
  filter_sum_stage_add5 #(.IN_W(8), .OUT_W(12)) u_wb_lo (
    .a(w_w[0]), .b(w_w[1]), .c(w_w[2]), .d(w_w[3]), .e(8'd0), .sum(w_wb_lo)
  );
  filter_sum_stage_add5 #(.IN_W(16), .OUT_W(20)) u_pa_hi (
    .a(w_p[4]), .b(w_p[5]), .c(w_p[6]), .d(w_p[7]), .e(w_p[8]), .sum(w_pa_hi)
  );
  filter_sum_stage_add5 #(.IN_W(16), .OUT_W(20)) u_pa_lo (
    .a(w_p[0]), .b(w_p[1]), .c(w_p[2]), .d(w_p[3]), .e(16'd0), .sum(w_pa_lo)
  );

  logic [63:0] r_pre;
  logic        r_pre_valid;
  logic [11:0] r_sum_b;
  logic [19:0] r_sum_a;
  logic        r_out_valid;

  logic [11:0] w_pre_wb_hi, w_pre_wb_lo;
  logic [19:0] w_pre_pa_hi, w_pre_pa_lo;

  assign w_pre_wb_hi = r_pre[63:52];
  assign w_pre_wb_lo = r_pre[51:40];
  assign w_pre_pa_hi = r_pre[39:20];
  assign w_pre_pa_lo = r_pre[19:0];

  // Data registers load on every enabled edge; only the valid bits qualify them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre       <= '0;
      r_pre_valid <= 1'b0;
      r_sum_b     <= '0;
      r_sum_a     <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.en) begin
      r_pre       <= {w_wb_hi, w_wb_lo, w_pa_hi, w_pa_lo};
      r_pre_valid <= bus.in_valid;
      r_sum_b     <= w_pre_wb_hi + w_pre_wb_lo;
      r_sum_a     <= w_pre_pa_hi + w_pre_pa_lo;
      r_out_valid <= r_pre_valid;
    end
  end

  assign bus.sum_b     = r_sum_b;
  assign bus.sum_a     = r_sum_a;
  assign bus.b_q       = r_sum_b[11:SHIFT];
  assign bus.a_q       = r_sum_a[19:SHIFT];
  assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_filter_sum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_sum_stage
// Brief    : Directed and randomized bench with a vector-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_sum_stage;
  localparam int SHIFT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  filter_sum_stage_if #(.SHIFT(SHIFT)) bus ();

  filter_sum_stage #(.SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [11:0] b;
    logic [19:0] a;
  } res_t;

  res_t m_s1  = '{1'b0, 12'd0, 20'd0};
  res_t m_out = '{1'b0, 12'd0, 20'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each enabled edge moves the previous vector's totals to the output.
  always @(posedge clk or negedge rst_n) begin
    int sb;
    int sa;
    if (!rst_n) begin
      m_s1  = '{1'b0, 12'd0, 20'd0};
      m_out = '{1'b0, 12'd0, 20'd0};
    end else if (bus.en) begin
      sb = 0;
      sa = 0;
      for (int k = 0; k < 9; k++) begin
        sb += int'(bus.w_bus[k*8 +: 8]);
        sa += int'(bus.p_bus[k*16 +: 16]);
      end
      m_out  = m_s1;
      m_s1.v = bus.in_valid;
      m_s1.b = 12'(sb);
      m_s1.a = 20'(sa);
    end
  end

  always @(negedge clk) begin
    chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_out.v));
    chk("mdl_sum_b",     32'(bus.sum_b),     32'(m_out.b));
    chk("mdl_sum_a",     32'(bus.sum_a),     32'(m_out.a));
    chk("mdl_b_q",       32'(bus.b_q),       32'(m_out.b >> SHIFT));
    chk("mdl_a_q",       32'(bus.a_q),       32'(m_out.a >> SHIFT));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string tag, input int sb, input int sa,
                         input int bq, input int aq, input int ov);
    chk({tag, "_sum_b"},     32'(bus.sum_b),     32'(sb));
    chk({tag, "_sum_a"},     32'(bus.sum_a),     32'(sa));
    chk({tag, "_b_q"},       32'(bus.b_q),       32'(bq));
    chk({tag, "_a_q"},       32'(bus.a_q),       32'(aq));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, "_model_b"},   32'(m_out.b),       32'(sb));
    chk({tag, "_model_a"},   32'(m_out.a),       32'(sa));
  endtask

  task automatic put(input int k, input logic [7:0] w, input logic [15:0] p);
    bus.w_bus[71 - 8*(k-1) -: 8]    = w;
    bus.p_bus[143 - 16*(k-1) -: 16] = p;
  endtask

  task automatic clear_vec();
    bus.w_bus = '0;
    bus.p_bus = '0;
  endtask

  task automatic set_ramp();
    for (int k = 1; k <= 9; k++) put(k, 8'(k), 16'(100*k));
  endtask

  task automatic set_max();
    bus.w_bus = '1;
    bus.p_bus = '1;
  endtask

  task automatic set_centre();
    clear_vec();
    put(5, 8'd248, 16'd61504);
  endtask

  task automatic set_lo();
    clear_vec();
    put(1, 8'd200, 16'd40000);
  endtask

  task automatic single(input string tag, input int sb, input int sa,
                        input int bq, input int aq);
    bus.en       = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    clear_vec();
    tick();
    chk_out(tag, sb, sa, bq, aq, 1);
  endtask

  initial begin
    logic [95:0]  t96;
    logic [159:0] t160;

    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    clear_vec();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    set_max();    single("max",    2295, 589815, 143, 36863);
    set_ramp();   single("ramp",   45,   4500,   2,   281);
    set_centre(); single("centre", 248,  61504,  15,  3844);
    set_lo();     single("lo",     200,  40000,  12,  2500);

    // Back-to-back vectors with a two-cycle stall in the middle.
    bus.en = 1'b1;
    bus.in_valid = 1'b1;
    set_ramp();   tick();
    set_max();    tick();
    chk_out("stream_ramp", 45, 4500, 2, 281, 1);
    set_centre(); tick();
    chk_out("stream_max", 2295, 589815, 143, 36863, 1);
    bus.en = 1'b0;
    set_ramp();
    tick();
    chk_out("stall1", 2295, 589815, 143, 36863, 1);
    tick();
    chk_out("stall2", 2295, 589815, 143, 36863, 1);
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk_out("stream_centre", 248, 61504, 15, 3844, 1);
    tick();
    chk("stream_drain_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-cycle with a full pipeline.
    set_max();
    bus.in_valid = 1'b1;
    tick();
    tick();
    chk("prefill_valid", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0);
    tick();
    tick();
    chk_out("rst_hold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk("post_rst_idle_valid", 32'(bus.out_valid), 32'd0);
    set_ramp();
    single("post_rst_ramp", 45, 4500, 2, 281);

    for (int i = 0; i < 400; i++) begin
      bus.en       = ($urandom % 4) != 0;
      bus.in_valid = 1'($urandom);
      if (($urandom % 8) == 0) begin
        set_max();
      end else begin
        t96  = {$urandom, $urandom, $urandom};
        t160 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bus.w_bus = t96[71:0];
        bus.p_bus = t160[143:0];
      end
      if (i == 200 || i == 301) begin
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/filter_sum_stage.md
# filter_sum_stage

Two-stage pipelined accumulation block for the 3x3 weighted-average filter datapath. It sums nine 8-bit weights and nine 16-bit weighted products, producing the 12-bit weight sum B and 20-bit product sum A. It also produces their right-shifted forms, which feed the downstream divider as dividend A and divisor B. Each sum is formed as two 5-input partial sums (stage 1), then one 2-input add (stage 2).

## Interface
Parameters:
- SHIFT, default 4: right-shift applied to A and B to form the quantized outputs.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  pipeline advance; 0 stalls every stage register.
- in_valid  in  1  qualifies w_bus/p_bus on this cycle.
- w_bus  in  72  nine unsigned 8-bit weights:
  - w1 at [71:64] … w9 at [7:0].
- p_bus  in  144  nine unsigned 16-bit products:
  - p1 at [143:128] … p9 at [15:0].
- sum_b  out  12  full weight sum B.
- sum_a  out  20  full product sum A.
- b_q  out  8  sum_b[11:4].
- a_q  out  16  sum_a[19:4].
- out_valid  out  1  outputs hold a valid result.

## Operation
- All arithmetic is unsigned and zero-extended; no saturation is needed.
- Weight sums:
  - Worst-case partial sum is 5·255 = 1275, which fits 12 bits.
  - Worst-case total is 9·255 = 2295, which fits 12 bits.
- Product sums:
  - Worst-case partial sum is 5·65535 = 327675, which fits 20 bits.
  - Worst-case total is 9·65535 = 589815, which fits 20 bits.
- Stage 1 (combinational from inputs, registered at end of stage):
  - wb_hi = w5+w6+w7+w8+w9 (12-bit).
  - wb_lo = w1+w2+w3+w4+0 (12-bit).
  - pa_hi = p5+…+p9 (20-bit).
  - pa_lo = p1+…+p4+0 (20-bit).
  - These four values go into the 64-bit pre register {wb_hi, wb_lo, pa_hi, pa_lo}.
  - Each 5-input adder is a reusable sub-unit: the 8-bit-input unit has a 12-bit output, the 16-bit-input unit has a 20-bit output. The unused fifth input is tied to 0.
- Stage 2 (registered):
  - sum_b = wb_hi + wb_lo (12-bit adder).
  - sum_a = pa_hi + pa_lo (20-bit adder).
- Quantized outputs are pure bit slices (truncation, no rounding):
  - b_q = sum_b >> 4.
  - a_q = sum_a >> 4.
  - They change on the same edge as sum_a/sum_b.
- Valid tracking:
  - in_valid is carried alongside the data through both stages to out_valid.
  - Data registers load regardless of in_valid. Only out_valid qualifies results.
- Stall (en=0):
  - Every register, including the valid bits, holds its value.
  - Inputs presented during stall cycles are ignored.

## Timing
- Latency is 2 clock edges with en=1. A vector sampled at edge N appears on the outputs after edge N+1 and is stable until edge N+2.
- Throughput is one vector per cycle. There are no bubbles and no backpressure other than en.
- Reset:
  - rst_n=0 asynchronously clears the pre register, the output registers and both valid bits.
  - While reset is asserted: sum_a=0, sum_b=0, a_q=0, b_q=0, out_valid=0.
- Reset mid-stream:
  - In-flight vectors are discarded.
  - After release, the first out_valid=1 occurs two enabled edges after the first sampled in_valid=1.
- Reset deassertion is synchronized by the system. The block only needs to honour asynchronous assertion.
- Simultaneous en=0 and rst_n=0: reset wins.

## Test plan
- Reset: drive rst_n=0 mid-cycle with nonzero pipeline contents.
  - Required: all outputs go to 0 immediately, without a clock edge.
- Maximum values: all w=255, all p=65535, in_valid=1, en=1.
  - Required, two edges later: sum_b=2295, sum_a=589815, b_q=143, a_q=36863, out_valid=1.
- Ramp: w_k=k and p_k=100·k for k=1..9.
  - Required: sum_b=45, sum_a=4500, b_q=2, a_q=281.
- Centre-only: w5=248, p5=61504, all others 0. This exercises the hi group only.
  - Required: sum_b=248, sum_a=61504, b_q=15, a_q=3844.
  - Repeat with only w1=200, p1=40000 to exercise the lo group only.
  - Required: sum_b=200, sum_a=40000, b_q=12, a_q=2500.
- Streaming and stall: feed ramp, max and centre vectors on three consecutive edges.
  - Required: results appear on three consecutive cycles in the same order.
  - Then drop en for two cycles mid-stream. Required: outputs and out_valid freeze, and the sequence resumes unchanged when en returns.
